sram_dp_param_clr: RTL and testbench
====================================

Name: sram_dp_param_clr

Overview:
- Parametrised dual-port register-file RAM: one write port and one read port on a single clock.
- Generalised data width, depth and read latency compared with the fixed 32x32 async-read array.
- Adds per-byte write enables, read-during-write bypass, and a hardware clear sequencer that initialises every entry after reset or on request.
- Used for CPU-side register files, CI scratch memories and small lookup tables that must power up in a known state.

Parameters:
- DATA_WIDTH, 32: word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 5: address width; depth DEPTH = 2**ADDR_WIDTH.
- READ_REGISTERED, 0: 0 = combinational read (latency 0); 1 = registered read (latency 1).
- BYPASS, 1: 1 = a read of the address being written in the same cycle returns the new data, byte-merged. 0 = the read returns the old array contents.
- CLEAR_VALUE, 0: DATA_WIDTH-bit value written to every entry by the clear sequence.

Ports:
- clock  in  1  single system clock; all state changes on its rising edge.
- resetN  in  1  asynchronous, active-low reset.
- clearRequest  in  1  pulse; starts a clear sequence when the block is idle.
- busy  out  1  high while reset is asserted or a clear sequence runs.
- writeEnable  in  1  write strobe.
- writeByteEnable  in  DATA_WIDTH/8  per-byte write mask; bit i covers bits [8i+7:8i].
- writeAddress  in  ADDR_WIDTH  write address.
- writeData  in  DATA_WIDTH  write data.
- readEnable  in  1  read strobe.
- readAddress  in  ADDR_WIDTH  read address.
- dataReadPort  out  DATA_WIDTH  read data.
- readValid  out  1  marks dataReadPort as valid.

Behaviour:
- Reset values (resetN low): state = CLEAR, clear counter = 0, busy = 1, readValid = 0, registered dataReadPort = CLEAR_VALUE. The array itself has no reset and is initialised only by the sequencer.
- FSM states: CLEAR, IDLE.
  - CLEAR: each rising edge writes CLEAR_VALUE to entry counter, then counter increments. When counter == DEPTH-1 is written, go to IDLE and return counter to 0.
  - After resetN rises: entries 0..DEPTH-1 are written on edges 1..DEPTH; busy falls after edge DEPTH.
  - IDLE: clearRequest = 1 enters CLEAR on the next edge; busy rises that edge.
- clearRequest while in CLEAR is ignored; it neither restarts nor extends the sequence.
- resetN asserted mid-clear: asynchronous return to CLEAR with counter = 0; the full sequence restarts after release.
- Write (IDLE and writeEnable = 1): bytes whose enable bit is 1 are updated at the edge; other bytes are unchanged. An all-zero mask is a no-op.
- While busy: writeEnable and readEnable are ignored. readValid = 0. dataReadPort = CLEAR_VALUE when READ_REGISTERED = 0; it holds its last value when READ_REGISTERED = 1.
- Read, READ_REGISTERED = 0:
  - dataReadPort = array[readAddress] combinationally.
  - readValid = readEnable & ~busy combinationally.
- Read, READ_REGISTERED = 1:
  - At an edge with readEnable & ~busy, the output register captures the read word and readValid = 1 for the following cycle.
  - Otherwise readValid = 0 and dataReadPort holds its last value.
- Bypass (BYPASS = 1, writeEnable, readEnable, writeAddress == readAddress, IDLE): the read word takes writeData bytes where the mask is 1 and old array bytes elsewhere. This applies to both latency modes.
- Bypass with BYPASS = 0: the registered mode returns old data; the combinational mode returns old data until the edge.
- Address wrap: the clear counter is ADDR_WIDTH+1 bits, or termination is detected at DEPTH-1, so it never re-clears entry 0.

Decomposition:
- Package sram_dp_param_pkg holds:
  - state enum {ST_IDLE, ST_CLEAR};
  - function byte_merge(old, new, mask) parametrised by DATA_WIDTH;
  - constant BYTES = DATA_WIDTH/8.
- One sub-module, sram_dp_param_core: the raw array with byte-enable synchronous write and asynchronous read, no reset.
- The top level holds the FSM, write-port mux (clear vs user), bypass merge and optional output register.

Test Plan (DATA_WIDTH = 32, ADDR_WIDTH = 5, CLEAR_VALUE = 0 unless noted):
- Reset released at cycle 0 -> busy = 1 for exactly 32 cycles. With CLEAR_VALUE = 32'hDEADBEEF, reading all 32 addresses afterwards returns 32'hDEADBEEF with readValid = 1.
- Write addr 7 = 32'h11223344 with mask 4'b1111, then mask 4'b0101 with data 32'hAABBCCDD -> read of addr 7 returns 32'h11BB33DD.
- READ_REGISTERED = 1: readEnable pulse on addr 3 holding 32'h5 -> dataReadPort = 32'h5 and readValid = 1 one cycle later, then readValid = 0 with data held.
- Same-cycle write/read of addr 9 (old 32'h0, new 32'hCAFEF00D, mask 4'b0011) -> BYPASS = 1 returns 32'h0000F00D; BYPASS = 0 returns 32'h0 in registered mode.
- clearRequest in IDLE after filling memory -> busy = 1 for 32 cycles, writes and reads during that window are ignored, all entries then read CLEAR_VALUE. A second clearRequest mid-sequence does not extend busy.
- resetN asserted at clear cycle 10, released 3 cycles later -> busy stays high for a fresh 32 cycles after release.

Source files
------------

// File: rtl/sram_dp_param_pkg.sv
// Shared types and helpers for the parametrised dual-port register-file RAM.
package sram_dp_param_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int BYTES              = DEFAULT_DATA_WIDTH / 8;

    // The merge works on the widest supported word; callers zero-extend and slice back.
    localparam int MERGE_WIDTH = 512;
    localparam int MERGE_BYTES = MERGE_WIDTH / 8;

    function automatic logic [MERGE_WIDTH-1:0] byte_merge(
        input logic [MERGE_WIDTH-1:0] old_word,
        input logic [MERGE_WIDTH-1:0] new_word,
        input logic [MERGE_BYTES-1:0] mask
    );
        logic [MERGE_WIDTH-1:0] merged;
        merged = old_word;
        for (int i = 0; i < MERGE_BYTES; i++) begin
            if (mask[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/sram_dp_param_core.sv
// Raw storage array: byte-enable synchronous write, asynchronous read, no reset.
module sram_dp_param_core #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                    clock,
    input  logic                    wr_en,
    input  logic [DATA_WIDTH/8-1:0] wr_be,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]   rd_data
);

    localparam int DEPTH  = 2 ** ADDR_WIDTH;
    localparam int NBYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (wr_be[i]) begin
                    mem_q[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/sram_dp_param_clr.sv
// Dual-port register-file RAM with byte enables, read-during-write bypass and a
// clear sequencer that walks every entry after reset or on clearRequest.
module sram_dp_param_clr
    import sram_dp_param_pkg::*;
#(
    parameter int                    DATA_WIDTH      = 32,
    parameter int                    ADDR_WIDTH      = 5,
    parameter bit                    READ_REGISTERED = 1'b0,
    parameter bit                    BYPASS          = 1'b1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE     = '0
) (
    input  logic                    clock,
    input  logic                    resetN,
    input  logic                    clearRequest,
    output logic                    busy,
    input  logic                    writeEnable,
    input  logic [DATA_WIDTH/8-1:0] writeByteEnable,
    input  logic [ADDR_WIDTH-1:0]   writeAddress,
    input  logic [DATA_WIDTH-1:0]   writeData,
    input  logic                    readEnable,
    input  logic [ADDR_WIDTH-1:0]   readAddress,
    output logic [DATA_WIDTH-1:0]   dataReadPort,
    output logic                    readValid,
    output state_t                  dbg_state
);

    localparam int                    NBYTES    = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;

    logic                    arr_we;
    logic [NBYTES-1:0]       arr_be;
    logic [ADDR_WIDTH-1:0]   arr_waddr;
    logic [DATA_WIDTH-1:0]   arr_wdata;
    logic [DATA_WIDTH-1:0]   core_rdata;
    logic [DATA_WIDTH-1:0]   merged_word;
    logic [DATA_WIDTH-1:0]   rd_word;
    logic                    bypass_hit;
    logic                    read_fire;

    // Termination is detected at the last address, so the counter never wraps onto entry 0.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == ST_CLEAR) begin
            if (clr_cnt_q == LAST_ADDR) begin
                state_d   = ST_IDLE;
                clr_cnt_d = '0;
            end else begin
                clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
            end
        end else if (clearRequest) begin
            state_d = ST_CLEAR;
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    assign busy      = (state_q == ST_CLEAR);
    assign dbg_state = state_q;

    always_comb begin
        if (busy) begin
            arr_we    = 1'b1;
            arr_be    = '1;
            arr_waddr = clr_cnt_q;
            arr_wdata = CLEAR_VALUE;
        end else begin
            arr_we    = writeEnable;
            arr_be    = writeByteEnable;
            arr_waddr = writeAddress;
            arr_wdata = writeData;
        end
    end

    sram_dp_param_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_core (
        .clock   (clock),
        .wr_en   (arr_we),
        .wr_be   (arr_be),
        .wr_addr (arr_waddr),
        .wr_data (arr_wdata),
        .rd_addr (readAddress),
        .rd_data (core_rdata)
    );

    // readValid qualifies dataReadPort for exactly the cycle it is high; there is no
    // back-pressure, so a read fires whenever readEnable is high outside a clear.
    assign read_fire   = readEnable & ~busy;
    assign bypass_hit  = BYPASS && !busy && writeEnable && readEnable
                         && (writeAddress == readAddress);
    assign merged_word = DATA_WIDTH'(byte_merge(MERGE_WIDTH'(core_rdata),
                                                MERGE_WIDTH'(writeData),
                                                MERGE_BYTES'(writeByteEnable)));
    assign rd_word     = bypass_hit ? merged_word : core_rdata;

    if (READ_REGISTERED) begin : g_reg
        logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
        logic                  rd_valid_q, rd_valid_d;

        always_comb begin
            rd_valid_d = read_fire;
            rd_data_d  = read_fire ? rd_word : rd_data_q;
        end

        always_ff @(posedge clock or negedge resetN) begin
            if (!resetN) begin
                rd_data_q  <= CLEAR_VALUE;
                rd_valid_q <= 1'b0;
            end else begin
                rd_data_q  <= rd_data_d;
                rd_valid_q <= rd_valid_d;
            end
        end

        assign dataReadPort = rd_data_q;
        assign readValid    = rd_valid_q;
    end else begin : g_comb
        assign dataReadPort = busy ? CLEAR_VALUE : rd_word;
        assign readValid    = read_fire;
    end

endmodule

// File: tb/tb_sram_dp_param_clr.sv
// Randomised scoreboard bench for sram_dp_param_clr: three configurations share one
// stimulus stream and are each compared against a per-entry reference memory.
module tb_sram_dp_param_clr;
    import sram_dp_param_pkg::*;

    localparam int          DEPTH = 32;
    localparam int          NDUT  = 3;
    localparam logic [31:0] CLR_A = 32'hDEADBEEF;
    localparam logic [31:0] CLR_B = 32'h0000_0000;
    localparam logic [31:0] CLR_C = 32'h5A5A_0F0F;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic resetN;
    always #5 clock = ~clock;

    logic        clearRequest;
    logic        writeEnable;
    logic [3:0]  writeByteEnable;
    logic [4:0]  writeAddress;
    logic [31:0] writeData;
    logic        readEnable;
    logic [4:0]  readAddress;

    logic [NDUT-1:0]       busy_o;
    logic [NDUT-1:0]       rvalid_o;
    logic [NDUT-1:0][31:0] rdata_o;
    state_t                dbg_a, dbg_b, dbg_c;
    logic [NDUT-1:0]       dbg_clear;
    assign dbg_clear = {dbg_c == ST_CLEAR, dbg_b == ST_CLEAR, dbg_a == ST_CLEAR};

    // dut 0: combinational read, bypass on;  dut 1: registered, bypass off;
    // dut 2: registered, bypass on.
    sram_dp_param_clr #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .READ_REGISTERED(1'b0),
                        .BYPASS(1'b1), .CLEAR_VALUE(CLR_A)) dut_a (
        .clock(clock), .resetN(resetN), .clearRequest(clearRequest), .busy(busy_o[0]),
        .writeEnable(writeEnable), .writeByteEnable(writeByteEnable),
        .writeAddress(writeAddress), .writeData(writeData), .readEnable(readEnable),
        .readAddress(readAddress), .dataReadPort(rdata_o[0]), .readValid(rvalid_o[0]),
        .dbg_state(dbg_a));

    sram_dp_param_clr #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .READ_REGISTERED(1'b1),
                        .BYPASS(1'b0), .CLEAR_VALUE(CLR_B)) dut_b (
        .clock(clock), .resetN(resetN), .clearRequest(clearRequest), .busy(busy_o[1]),
        .writeEnable(writeEnable), .writeByteEnable(writeByteEnable),
        .writeAddress(writeAddress), .writeData(writeData), .readEnable(readEnable),
        .readAddress(readAddress), .dataReadPort(rdata_o[1]), .readValid(rvalid_o[1]),
        .dbg_state(dbg_b));

    sram_dp_param_clr #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .READ_REGISTERED(1'b1),
                        .BYPASS(1'b1), .CLEAR_VALUE(CLR_C)) dut_c (
        .clock(clock), .resetN(resetN), .clearRequest(clearRequest), .busy(busy_o[2]),
        .writeEnable(writeEnable), .writeByteEnable(writeByteEnable),
        .writeAddress(writeAddress), .writeData(writeData), .readEnable(readEnable),
        .readAddress(readAddress), .dataReadPort(rdata_o[2]), .readValid(rvalid_o[2]),
        .dbg_state(dbg_c));

    // ---------------- reference model ----------------
    logic [31:0] mem_m [NDUT][DEPTH];
    int          m_left;
    int          cyc;
    logic [31:0] last_m [NDUT];

    function automatic logic [31:0] clr_val(input int k);
        case (k)
            0:       return CLR_A;
            1:       return CLR_B;
            default: return CLR_C;
        endcase
    endfunction

    function automatic bit is_reg(input int k);
        return k != 0;
    endfunction

    function automatic bit has_bypass(input int k);
        return k != 1;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
        logic [31:0] m;
        m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (new_w & m) | (old_w & ~m);
    endfunction

    function automatic void fill_clear();
        for (int k = 0; k < NDUT; k++)
            for (int a = 0; a < DEPTH; a++)
                mem_m[k][a] = clr_val(k);
    endfunction

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q   [NDUT][$];
    int          stamp_q [NDUT][$];
    int          checks   = 0;
    int          failures = 0;

    task automatic check(input string name, input int k, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d cyc=%0d got=%h expected=%h", name, k, cyc, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        logic [31:0] e;
        if (resetN && m_left == 0 && readEnable) begin
            for (int k = 0; k < NDUT; k++) begin
                e = mem_m[k][readAddress];
                if (has_bypass(k) && writeEnable && writeAddress == readAddress)
                    e = merge(e, writeData, writeByteEnable);
                exp_q[k].push_back(e);
                stamp_q[k].push_back(is_reg(k) ? cyc + 1 : cyc);
            end
        end
        @(posedge clock);
        if (resetN) begin
            if (m_left > 0) begin
                m_left--;
            end else begin
                if (writeEnable)
                    for (int k = 0; k < NDUT; k++)
                        mem_m[k][writeAddress] = merge(mem_m[k][writeAddress], writeData,
                                                       writeByteEnable);
                if (clearRequest) begin
                    m_left = DEPTH;
                    fill_clear();
                end
            end
        end
        cyc++;
        #1;
    endtask

    task automatic drive(input logic we, input logic [3:0] be, input logic [4:0] wa,
                         input logic [31:0] wd, input logic re, input logic [4:0] ra,
                         input logic clr);
        writeEnable     = we;
        writeByteEnable = be;
        writeAddress    = wa;
        writeData       = wd;
        readEnable      = re;
        readAddress     = ra;
        clearRequest    = clr;
        tick();
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 4'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic read_all();
        for (int a = 0; a < DEPTH; a++) drive(1'b0, 4'h0, 5'd0, 32'h0, 1'b1, 5'(a), 1'b0);
    endtask

    task automatic random_cycle(input logic clr);
        drive(1'($urandom_range(0, 1)), 4'($urandom), 5'($urandom_range(0, 7)), $urandom,
              1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), clr);
    endtask

    task automatic apply_reset(input int n);
        idle(1);
        resetN = 1'b0;
        m_left = DEPTH;
        fill_clear();
        idle(n);
        resetN = 1'b1;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clock) begin
        logic exp_busy;
        logic [31:0] e;
        exp_busy = !resetN || m_left > 0;
        for (int k = 0; k < NDUT; k++) begin
            check("busy", k, 32'(busy_o[k]), 32'(exp_busy));
            check("dbg_state", k, 32'(dbg_clear[k]), 32'(exp_busy));
            while (stamp_q[k].size() > 0 && stamp_q[k][0] < cyc) begin
                checks++;
                failures++;
                $display("FAIL read_missing dut%0d cyc=%0d got=no_valid expected=valid_at_%0d",
                         k, cyc, stamp_q[k][0]);
                void'(stamp_q[k].pop_front());
                void'(exp_q[k].pop_front());
            end
            if (rvalid_o[k]) begin
                if (stamp_q[k].size() > 0 && stamp_q[k][0] == cyc) begin
                    void'(stamp_q[k].pop_front());
                    e = exp_q[k].pop_front();
                    check("read_data", k, rdata_o[k], e);
                    last_m[k] = e;
                end else begin
                    checks++;
                    failures++;
                    $display("FAIL read_unexpected dut%0d cyc=%0d got=valid expected=no_valid",
                             k, cyc);
                end
            end else if (is_reg(k)) begin
                if (!resetN) last_m[k] = clr_val(k);
                check("read_hold", k, rdata_o[k], last_m[k]);
            end else if (exp_busy) begin
                check("busy_data", k, rdata_o[k], clr_val(k));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        resetN          = 1'b0;
        clearRequest    = 1'b0;
        writeEnable     = 1'b0;
        writeByteEnable = 4'h0;
        writeAddress    = 5'd0;
        writeData       = 32'h0;
        readEnable      = 1'b0;
        readAddress     = 5'd0;
        cyc             = 0;
        m_left          = DEPTH;
        fill_clear();
        for (int k = 0; k < NDUT; k++) last_m[k] = clr_val(k);

        idle(3);
        resetN = 1'b1;
        idle(DEPTH + 2);
        read_all();

        drive(1'b1, 4'b1111, 5'd7, 32'h11223344, 1'b0, 5'd0, 1'b0);
        drive(1'b1, 4'b0101, 5'd7, 32'hAABBCCDD, 1'b0, 5'd0, 1'b0);
        drive(1'b0, 4'b0000, 5'd0, 32'h0, 1'b1, 5'd7, 1'b0);
        idle(1);

        drive(1'b1, 4'b1111, 5'd3, 32'h5, 1'b0, 5'd0, 1'b0);
        drive(1'b0, 4'b0000, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0);
        idle(3);

        drive(1'b1, 4'b1111, 5'd9, 32'h0, 1'b0, 5'd0, 1'b0);
        drive(1'b1, 4'b0011, 5'd9, 32'hCAFEF00D, 1'b1, 5'd9, 1'b0);
        drive(1'b0, 4'b0000, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0);
        idle(2);

        for (int a = 0; a < DEPTH; a++) drive(1'b1, 4'hF, 5'(a), $urandom, 1'b0, 5'd0, 1'b0);
        drive(1'b0, 4'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1);
        for (int i = 0; i < DEPTH + 6; i++) random_cycle(i == 12);
        read_all();

        drive(1'b0, 4'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1);
        idle(10);
        apply_reset(3);
        idle(DEPTH + 2);
        for (int a = 0; a < 6; a++) drive(1'b0, 4'h0, 5'd0, 32'h0, 1'b1, 5'(a * 5), 1'b0);

        for (int i = 0; i < 400; i++) random_cycle(1'($urandom_range(0, 99) == 0));
        idle(DEPTH + 4);
        read_all();
        idle(3);

        for (int k = 0; k < NDUT; k++) check("queue_drained", k, 32'(exp_q[k].size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
